buffered_out_device: RTL and testbench
======================================

Name: buffered_out_device

Overview:
- Memory-mapped output peripheral that hangs directly downstream of the bridge's output-device write path (bridge `out_wd`, `outdevice_we`, 2-bit register select).
- CPU stores are queued in a FIFO. The FIFO drains one word per programmable period onto an external valid/ready port.
- Raises a level interrupt on `hwint` when the FIFO runs empty or overflows.
- Read-back of status/peek data goes to the bridge read mux.

Parameters:
- DEPTH, 8, FIFO entries; must be a power of two, minimum 2.
- AW, 3, log2(DEPTH); FIFO pointer width.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- addr  in  2  register select from bridge
- we  in  1  write strobe from bridge, one cycle per store
- wdata  in  32  store data from bridge
- rdata  out  32  combinational read data for current addr
- irq  out  1  registered level interrupt to bridge hwint
- dout  out  32  drained word to external sink
- dout_valid  out  1  dout holds a valid word
- dout_ready  in  1  sink accepts dout this cycle

Behaviour:

Register map:
- addr 0 DATA
  - Write pushes wdata.
  - Read returns the head word, or 0 if empty.
- addr 1 CTRL
  - [0] EN: drain enable.
  - [1] IE: interrupt enable.
  - [2] OVF: sticky, write-1-to-clear.
  - Writes to [0] and [1] load directly.
  - Read returns {29'b0, OVF, IE, EN}.
- addr 2 DIV
  - [15:0] drain period in cycles; the value 0 is treated as 1.
  - Read returns {16'b0, DIV}.
- addr 3 STATUS (read-only; writes ignored)
  - [0] empty, [1] full, [2] OVF, [AW+3:3] count (0..DEPTH), rest 0.

FIFO:
- Circular buffer with wr_ptr/rd_ptr (AW bits, wrapping DEPTH-1 -> 0) and an AW+1-bit count.
- Push and pop in the same edge: both take effect, count unchanged.
- Full/empty decisions use pre-edge values.
  - A push while full is dropped and sets OVF, even with a simultaneous pop.
  - A pop only occurs in PRESENT, so the FIFO is never empty at pop time.

Drain FSM:
- IDLE
  - EN=1 and !empty: go to WAIT, cnt <= max(DIV,1)-1.
- WAIT
  - EN=0: go to IDLE.
  - Else if cnt==0: go to PRESENT.
  - Else cnt <= cnt-1.
- PRESENT
  - dout_valid=1, dout=head, held stable until the handshake.
  - On dout_ready=1: pop. Then, if EN=1 and the post-pop FIFO is non-empty, go to WAIT reloading cnt; else go to IDLE.
  - Clearing EN in PRESENT does not retract valid; the block completes the handshake first.
- Latency: a push at edge t into an empty FIFO with EN=1 sets dout_valid high from edge t+1+max(DIV,1).
- dout is registered: loaded with head on entry to PRESENT, and 0 outside PRESENT.

Interrupt:
- irq <= IE & (empty | OVF), registered, one cycle behind state.
- Software clears it by filling the FIFO, writing OVF=1, or clearing IE.

Reset (async, rst=1):
- ptrs=0, count=0, EN=0, IE=0, OVF=0, DIV=1, FSM=IDLE, cnt=0.
- dout=0, dout_valid=0, irq=0.
- Reset mid-handshake drops dout_valid immediately and discards all queued data.

Test Plan:
- Reset, then write CTRL=3 (EN=1, IE=1): STATUS reads 0x1; irq=1 one cycle after the CTRL write edge; dout_valid=0.
- DIV=4, dout_ready=1, push 0xA5A5_0001 at edge t: dout_valid first high at edge t+5 with dout=0xA5A5_0001; pops that edge; STATUS returns 0x1 and irq reasserts the next cycle.
- DIV=2, EN=0, push 9 words 1..9 (DEPTH=8): STATUS full=1, count=8, OVF=1, irq=1. Write CTRL=0x7: OVF clears, irq=0. Then set EN=1: sink receives exactly 1..8 in order, one every 3 cycles.
- dout_ready held 0 for 10 cycles in PRESENT with head 0x1234: dout and dout_valid stay constant. Clearing EN meanwhile does not drop valid; raise ready: one pop, FSM goes to IDLE.
- FIFO holds 3 words; push and pop land on the same edge: count stays 3, the new word is appended, and wrap-around of wr_ptr past DEPTH-1 preserves order.
- Assert rst asynchronously mid-WAIT with 5 words queued: outputs zero immediately; after release STATUS=0x1 and no dout_valid.

Source files
------------

// File: rtl/buffered_out_device.sv
// Buffered output peripheral: CPU stores are queued in a FIFO and drained one
// word per programmable period onto a valid/ready sink, with a level interrupt.
// Ports: clk, rst (async, active high); addr/we/wdata (write path from the
// bridge); rdata (combinational read-back for addr); irq (registered
// interrupt); dout/dout_valid/dout_ready (valid/ready sink port).
module buffered_out_device #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq,
  output logic [31:0] dout,
  output logic        dout_valid,
  input  logic        dout_ready
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    PRESENT = 2'd2
  } state_e;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          en_q, en_d;
  logic          ie_q, ie_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   div_q, div_d;
  logic [15:0]   cnt_q, cnt_d;
  state_e        state_q, state_d;
  logic [31:0]   dout_q, dout_d;
  logic          irq_q, irq_d;

  logic        empty;
  logic        full;
  logic        push_req;
  logic        push_ok;
  logic        pop;
  logic        ctrl_we;
  logic        div_we;
  logic [15:0] reload;
  logic [31:0] head;

  assign empty    = (count_q == '0);
  assign full     = (count_q == FULL_CNT);
  assign push_req = we && (addr == 2'd0);
  assign ctrl_we  = we && (addr == 2'd1);
  assign div_we   = we && (addr == 2'd2);
  // Full is judged on the pre-edge count, so a pop cannot make room.
  assign push_ok  = push_req && !full;
  assign pop      = (state_q == PRESENT) && dout_ready;
  assign head     = mem_q[rd_ptr_q];
  // A period of 0 behaves as 1.
  assign reload   = (div_q == 16'd0) ? 16'd0 : div_q - 16'd1;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    en_d  = en_q;
    ie_d  = ie_q;
    ovf_d = ovf_q;
    div_d = div_q;
    if (push_req && full) begin
      ovf_d = 1'b1;
    end
    if (ctrl_we) begin
      en_d = wdata[0];
      ie_d = wdata[1];
      if (wdata[2]) ovf_d = 1'b0;
    end
    if (div_we) div_d = wdata[15:0];
    irq_d = ie_q & (empty | ovf_q);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (en_q && !empty) begin
          state_d = WAIT;
          cnt_d   = reload;
        end
      end
      WAIT: begin
        if (!en_q) begin
          state_d = IDLE;
        end else if (cnt_q == 16'd0) begin
          state_d = PRESENT;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      PRESENT: begin
        // EN is only consulted after the handshake completes.
        if (dout_ready) begin
          if (en_q && (count_d != '0)) begin
            state_d = WAIT;
            cnt_d   = reload;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // dout captures the head on entry to PRESENT and holds until the pop.
  always_comb begin
    dout_d = 32'd0;
    if (state_d == PRESENT) begin
      dout_d = (state_q == PRESENT) ? dout_q : head;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      en_q     <= 1'b0;
      ie_q     <= 1'b0;
      ovf_q    <= 1'b0;
      div_q    <= 16'd1;
      cnt_q    <= 16'd0;
      state_q  <= IDLE;
      dout_q   <= 32'd0;
      irq_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      en_q     <= en_d;
      ie_q     <= ie_d;
      ovf_q    <= ovf_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      dout_q   <= dout_d;
      irq_q    <= irq_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = (state_q == PRESENT);
  assign irq        = irq_q;

  always_comb begin
    rdata = 32'd0;
    unique case (addr)
      2'd0: rdata = empty ? 32'd0 : head;
      2'd1: rdata = {29'd0, ovf_q, ie_q, en_q};
      2'd2: rdata = {16'd0, div_q};
      2'd3: rdata = 32'({count_q, ovf_q, full, empty});
      default: rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_buffered_out_device.sv
// Self-checking bench for buffered_out_device: directed scenarios plus random
// traffic, compared every cycle against a queue/timer reference model.
module tb_buffered_out_device;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  addr = 2'd0;
  logic        we = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic        dout_ready = 1'b0;
  logic [31:0] rdata;
  logic        irq;
  logic [31:0] dout;
  logic        dout_valid;

  buffered_out_device #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .addr       (addr),
    .we         (we),
    .wdata      (wdata),
    .rdata      (rdata),
    .irq        (irq),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: a word queue plus a "present at edge" timer.
  logic [31:0] q[$];
  bit          m_en, m_ie, m_ovf;
  logic [15:0] m_div;
  bit          m_valid, m_busy, m_irq;
  int          m_tp;
  int          m_n;
  logic [31:0] m_dout;

  task automatic mreset();
    q.delete();
    m_en = 0; m_ie = 0; m_ovf = 0; m_div = 16'd1;
    m_valid = 0; m_busy = 0; m_irq = 0; m_tp = 0;
    m_dout = 32'd0;
  endtask

  function automatic logic [31:0] mread(logic [1:0] a);
    int sz = q.size();
    case (a)
      2'd0: return (sz != 0) ? q[0] : 32'd0;
      2'd1: return {29'd0, m_ovf, m_ie, m_en};
      2'd2: return {16'd0, m_div};
      default: return 32'(sz == 0) | (32'(sz == DEPTH) << 1) |
                      (32'(m_ovf) << 2) | (32'(sz) << 3);
    endcase
  endfunction

  task automatic mstep();
    int          sz    = q.size();
    bit          pushr = we && (addr == 2'd0);
    bit          en0   = m_en;
    int          per   = (m_div == 16'd0) ? 1 : int'(m_div);
    logic [31:0] head0 = (sz != 0) ? q[0] : 32'd0;
    bit          irq_n = m_ie && ((sz == 0) || m_ovf);
    bit          popd  = m_valid && dout_ready;
    if (popd) void'(q.pop_front());
    if (pushr) begin
      if (sz == DEPTH) m_ovf = 1;
      else q.push_back(wdata);
    end
    if (m_valid) begin
      if (dout_ready) begin
        m_valid = 0;
        m_dout  = 32'd0;
        if (en0 && q.size() > 0) begin
          m_busy = 1;
          m_tp   = m_n + per;
        end
      end
    end else if (m_busy) begin
      if (!en0) begin
        m_busy = 0;
      end else if (m_n == m_tp) begin
        m_busy  = 0;
        m_valid = 1;
        m_dout  = head0;
      end
    end else if (en0 && sz > 0) begin
      m_busy = 1;
      m_tp   = m_n + per;
    end
    if (we && addr == 2'd1) begin
      m_en = wdata[0];
      m_ie = wdata[1];
      if (wdata[2]) m_ovf = 0;
    end
    if (we && addr == 2'd2) m_div = wdata[15:0];
    m_irq = irq_n;
    m_n++;
  endtask

  task automatic cycle();
    @(posedge clk);
    mstep();
    #1;
    chk("dout_valid", 32'(dout_valid), 32'(m_valid));
    chk("dout", dout, m_dout);
    chk("irq", 32'(irq), 32'(m_irq));
    chk("rdata", rdata, mread(addr));
  endtask

  task automatic wr(logic [1:0] a, logic [31:0] d);
    addr  = a;
    we    = 1'b1;
    wdata = d;
    cycle();
    we    = 1'b0;
  endtask

  task automatic wait_valid(string tag, int lim);
    int k = 0;
    while (!dout_valid && k < lim) begin
      cycle();
      k++;
    end
    chk(tag, 32'(dout_valid), 32'd1);
  endtask

  logic [31:0] got[$];
  int          at[$];

  initial begin
    int k;
    mreset();
    m_n = 0;
    #2;
    chk("rst_valid", 32'(dout_valid), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    #20 rst = 1'b0;

    // Enable + interrupt on empty FIFO.
    wr(2'd1, 32'd3);
    addr = 2'd3;
    #1 chk("status_after_rst", rdata, 32'h1);
    cycle();
    chk("irq_empty", 32'(irq), 32'd1);

    // Latency with DIV=4.
    wr(2'd2, 32'd4);
    dout_ready = 1'b1;
    wr(2'd0, 32'hA5A5_0001);
    k = 0;
    while (!dout_valid && k < 20) begin
      cycle();
      k++;
    end
    chk("latency", 32'(k), 32'd5);
    chk("first_dout", dout, 32'hA5A5_0001);
    addr = 2'd3;
    cycle();
    chk("status_drained", rdata, 32'h1);
    cycle();
    chk("irq_reassert", 32'(irq), 32'd1);

    // Overflow then ordered drain with DIV=2.
    wr(2'd1, 32'd2);
    wr(2'd2, 32'd2);
    for (int i = 1; i <= 9; i++) wr(2'd0, 32'(i));
    addr = 2'd3;
    cycle();
    chk("status_full_ovf", rdata, 32'h46);
    chk("irq_ovf", 32'(irq), 32'd1);
    wr(2'd1, 32'd7);
    cycle();
    chk("irq_cleared", 32'(irq), 32'd0);
    got.delete();
    at.delete();
    for (int c = 0; c < 60; c++) begin
      cycle();
      if (dout_valid && dout_ready) begin
        got.push_back(dout);
        at.push_back(c);
      end
    end
    chk("drain_count", 32'(got.size()), 32'd8);
    for (int i = 0; i < got.size(); i++) begin
      chk("drain_order", got[i], 32'(i + 1));
      if (i > 0) chk("drain_gap", 32'(at[i] - at[i-1]), 32'd3);
    end

    // Back-pressure hold, EN cleared during PRESENT.
    wr(2'd2, 32'd1);
    dout_ready = 1'b0;
    wr(2'd0, 32'h1234);
    wait_valid("hold_reach", 20);
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("hold_dout", dout, 32'h1234);
    end
    wr(2'd1, 32'd2);
    chk("hold_en_off", 32'(dout_valid), 32'd1);
    dout_ready = 1'b1;
    cycle();
    dout_ready = 1'b0;
    cycle();
    chk("hold_done", 32'(dout_valid), 32'd0);

    // Simultaneous push and pop with 3 words queued.
    for (int i = 0; i < 3; i++) wr(2'd0, 32'h100 + 32'(i));
    wr(2'd1, 32'd3);
    wait_valid("pp_reach", 20);
    dout_ready = 1'b1;
    wr(2'd0, 32'h200);
    addr = 2'd3;
    #1 chk("pp_count", rdata, 32'(3 << 3));
    for (int i = 0; i < 30; i++) cycle();

    // Async reset while waiting with 5 words queued.
    wr(2'd1, 32'd0);
    for (int i = 0; i < 5; i++) wr(2'd0, 32'h300 + 32'(i));
    wr(2'd2, 32'd50);
    wr(2'd1, 32'd1);
    for (int i = 0; i < 5; i++) cycle();
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(dout_valid), 32'd0);
    chk("arst_dout", dout, 32'd0);
    chk("arst_irq", 32'(irq), 32'd0);
    mreset();
    @(negedge clk);
    rst = 1'b0;
    addr = 2'd3;
    #1 chk("arst_status", rdata, 32'h1);
    for (int i = 0; i < 3; i++) cycle();

    // Async reset while presenting.
    dout_ready = 1'b0;
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h77);
    wait_valid("prst_reach", 20);
    #2 rst = 1'b1;
    #1 chk("prst_valid", 32'(dout_valid), 32'd0);
    mreset();
    @(negedge clk);
    rst = 1'b0;
    cycle();

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      logic [1:0] a;
      a = ($urandom % 2 == 0) ? 2'd0 : 2'($urandom_range(0, 3));
      addr = a;
      we = ($urandom % 3 == 0);
      case (a)
        2'd1: wdata = {29'd0, 1'($urandom % 5 == 0), 1'($urandom % 2),
                       1'($urandom % 4 != 0)};
        2'd2: wdata = 32'($urandom_range(0, 3));
        default: wdata = $urandom;
      endcase
      dout_ready = ($urandom % 4 != 0);
      cycle();
    end
    we = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
